regfile_port_arbiter: RTL and testbench

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

---
 rtl/regfile_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Two-port round-robin arbiter that serialises requester A/B accesses onto one register-array port.
// Latency: grant and write strobe one cycle after req is sampled; read data valid two cycles after.
// Backpressure: a requester holds req until its gnt pulse; req is sampled only while IDLE.
//
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   reqX/weX/addrX/dataX         requester A/B transaction request (X = A, B)
//   gntX, rdValidX               per-requester grant pulse and read-result pulse
//   rdDataOut                    registered read result, held until the next read
//   wrEn/wrAddr/wrData           write port towards the register array
//   rdAddr/rdData                read port towards the register array (rdData combinational)
//   busy                         arbiter is in the middle of a transaction
module regfile_port_arbiter #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqA,
    input  logic                 reqB,
    input  logic                 weA,
    input  logic                 weB,
    input  logic [BITS_ADDR-1:0] addrA,
    input  logic [BITS_ADDR-1:0] addrB,
    input  logic [BITS_DATA-1:0] dataA,
    input  logic [BITS_DATA-1:0] dataB,
    output logic                 gntA,
    output logic                 gntB,
    output logic                 rdValidA,
    output logic                 rdValidB,
    output logic [BITS_DATA-1:0] rdDataOut,
    output logic                 wrEn,
    output logic [BITS_ADDR-1:0] wrAddr,
    output logic [BITS_DATA-1:0] wrData,
    output logic [BITS_ADDR-1:0] rdAddr,
    input  logic [BITS_DATA-1:0] rdData,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic                   last_b_q,    last_b_d;   // 1: B was granted last
    logic                   win_b_q,     win_b_d;    // 1: current transaction belongs to B
    logic                   we_q,        we_d;
    logic [BITS_ADDR-1:0]   wr_addr_q,   wr_addr_d;
    logic [BITS_DATA-1:0]   wr_data_q,   wr_data_d;
    logic [BITS_ADDR-1:0]   rd_addr_q,   rd_addr_d;
    logic [BITS_DATA-1:0]   rd_data_q,   rd_data_d;

    logic                   pick_b;
    logic                   pick_we;
    logic [BITS_ADDR-1:0]   pick_addr;
    logic [BITS_DATA-1:0]   pick_data;

    // Winner selection: a sole requester wins; on a tie the requester that
    // was not granted last wins.
    always_comb begin
        pick_b    = reqB && (!reqA || !last_b_q);
        pick_we   = pick_b ? weB   : weA;
        pick_addr = pick_b ? addrB : addrA;
        pick_data = pick_b ? dataB : dataA;
    end

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        win_b_d   = win_b_q;
        we_d      = we_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (reqA || reqB) begin
                    state_d  = ST_ISSUE;
                    last_b_d = pick_b;
                    win_b_d  = pick_b;
                    we_d     = pick_we;
                    // The address/data land directly in the port registers so
                    // the array sees them for the whole ISSUE cycle and they
                    // hold afterwards; only the port actually used is updated.
                    if (pick_we) begin
                        wr_addr_d = pick_addr;
                        wr_data_d = pick_data;
                    end else begin
                        rd_addr_d = pick_addr;
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_RESP;
                    rd_data_d = rdData;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;   // A wins the first tie after reset
            win_b_q   <= 1'b0;
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            win_b_q   <= win_b_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Strobes are qualified with reset so that a reset arriving during ISSUE
    // or RESP suppresses the write/grant/valid in that very cycle; the state
    // register then returns to IDLE and the aborted transaction is dropped.
    logic issue_act;
    logic resp_act;

    always_comb begin
        issue_act = (state_q == ST_ISSUE) && !reset;
        resp_act  = (state_q == ST_RESP)  && !reset;
        gntA      = issue_act && !win_b_q;
        gntB      = issue_act &&  win_b_q;
        wrEn      = issue_act &&  we_q;
        rdValidA  = resp_act  && !win_b_q;
        rdValidB  = resp_act  &&  win_b_q;
        busy      = (state_q != ST_IDLE);
    end

    assign wrAddr    = wr_addr_q;
    assign wrData    = wr_data_q;
    assign rdAddr    = rd_addr_q;
    assign rdDataOut = rd_data_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: directed scenarios plus a randomized run
// Latency model: grant/write at T+1, read valid at T+2 after the IDLE sampling edge.
// Backpressure: requesters hold req until granted; stray pulses are injected while busy.
module tb_regfile_port_arbiter;

    logic        clk;
    logic        reset;
    logic        reqA, reqB, weA, weB;
    logic [2:0]  addrA, addrB;
    logic [31:0] dataA, dataB;
    logic        gntA, gntB, rdValidA, rdValidB;
    logic [31:0] rdDataOut;
    logic        wrEn;
    logic [2:0]  wrAddr;
    logic [31:0] wrData;
    logic [2:0]  rdAddr;
    logic [31:0] rdData;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Register array seen by the arbiter.
    logic [31:0] mem [8];
    always @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end
    assign rdData = mem[rdAddr];

    regfile_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(3)) dut (
        .clk(clk), .reset(reset),
        .reqA(reqA), .reqB(reqB), .weA(weA), .weB(weB),
        .addrA(addrA), .addrB(addrB), .dataA(dataA), .dataB(dataB),
        .gntA(gntA), .gntB(gntB), .rdValidA(rdValidA), .rdValidB(rdValidB),
        .rdDataOut(rdDataOut), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr(rdAddr), .rdData(rdData), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1; reqA = 1'b0; reqB = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; reqA = 0; reqB = 0; weA = 0; weB = 0;
        addrA = 0; addrB = 0; dataA = 0; dataB = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({gntA, gntB, rdValidA, rdValidB, wrEn, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000", {gntA, gntB, rdValidA, rdValidB, wrEn, busy});
        end
        checks++;
        if (wrAddr !== 3'd0 || rdAddr !== 3'd0) begin
            errors++;
            $display("FAIL reset_addr got wr=%0d rd=%0d want 0 0", wrAddr, rdAddr);
        end
        checks++;
        if (wrData !== 32'd0 || rdDataOut !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got wr=%h rd=%h want 0 0", wrData, rdDataOut);
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        reqA = 1; weA = 1; addrA = 3; dataA = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({gntA, gntB, wrEn, busy} !== 4'b1011 || wrAddr !== 3'd3 || wrData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_issue got gA%b gB%b we%b busy%b a=%0d d=%h want 1 0 1 1 a=3 d=deadbeef",
                     gntA, gntB, wrEn, busy, wrAddr, wrData);
        end
        reqA = 0;
        @(negedge clk);
        checks++;
        if (wrEn !== 1'b0 || busy !== 1'b0 || gntA !== 1'b0) begin
            errors++;
            $display("FAIL write_after got we%b busy%b gA%b want 0 0 0", wrEn, busy, gntA);
        end
    endtask

    task automatic test_read();
        // place 0x12345678 in R5 through port B, then read it back via B
        reqB = 1; weB = 1; addrB = 5; dataB = 32'h12345678;
        @(negedge clk);
        reqB = 0;
        @(negedge clk);
        reqB = 1; weB = 0; addrB = 5;
        @(negedge clk);
        checks++;
        if (gntB !== 1'b1 || gntA !== 1'b0 || wrEn !== 1'b0 || rdAddr !== 3'd5 || rdValidB !== 1'b0) begin
            errors++;
            $display("FAIL read_issue got gB%b gA%b we%b rdAddr=%0d rv%b want 1 0 0 5 0",
                     gntB, gntA, wrEn, rdAddr, rdValidB);
        end
        reqB = 0;
        @(negedge clk);
        checks++;
        if (rdValidB !== 1'b1 || rdValidA !== 1'b0 || rdDataOut !== 32'h12345678 || busy !== 1'b1 || gntB !== 1'b0) begin
            errors++;
            $display("FAIL read_resp got rvB%b rvA%b d=%h busy%b gB%b want 1 0 12345678 1 0",
                     rdValidB, rdValidA, rdDataOut, busy, gntB);
        end
        @(negedge clk);
        checks++;
        if (rdValidB !== 1'b0 || busy !== 1'b0 || rdDataOut !== 32'h12345678) begin
            errors++;
            $display("FAIL read_hold got rvB%b busy%b d=%h want 0 0 12345678", rdValidB, busy, rdDataOut);
        end
    endtask

    task automatic test_contention();
        logic expA, expB;
        do_reset();
        reqA = 1; weA = 1; addrA = 0; dataA = 32'hAAAA0000;
        reqB = 1; weB = 1; addrB = 7; dataB = 32'hBBBB0007;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            expA = (k % 2 == 1) && (((k - 1) / 2) % 2 == 0);
            expB = (k % 2 == 1) && (((k - 1) / 2) % 2 == 1);
            checks++;
            if (gntA !== expA || gntB !== expB || wrEn !== (expA | expB)) begin
                errors++;
                $display("FAIL contention k=%0d got gA%b gB%b we%b want %b %b %b",
                         k, gntA, gntB, wrEn, expA, expB, expA | expB);
            end
            if (expA || expB) begin
                checks++;
                if (wrAddr !== (expA ? 3'd0 : 3'd7)) begin
                    errors++;
                    $display("FAIL contention_addr k=%0d got %0d want %0d", k, wrAddr, expA ? 0 : 7);
                end
            end
        end
        reqA = 0; reqB = 0;
        @(negedge clk);
    endtask

    task automatic test_rw_same_addr();
        // prior B grant writes the old R2 value
        reqB = 1; weB = 1; addrB = 2; dataB = 32'h11112222;
        @(negedge clk);
        reqB = 0;
        @(negedge clk);
        reqA = 1; weA = 0; addrA = 2;
        reqB = 1; weB = 1; addrB = 2; dataB = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if (gntA !== 1'b1 || gntB !== 1'b0 || rdAddr !== 3'd2) begin
            errors++;
            $display("FAIL rw_first got gA%b gB%b rdAddr=%0d want 1 0 2", gntA, gntB, rdAddr);
        end
        reqA = 0;
        @(negedge clk);
        checks++;
        if (rdValidA !== 1'b1 || rdDataOut !== 32'h11112222) begin
            errors++;
            $display("FAIL rw_old_data got rvA%b d=%h want 1 11112222", rdValidA, rdDataOut);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gntB !== 1'b1 || wrEn !== 1'b1 || wrAddr !== 3'd2 || wrData !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL rw_second got gB%b we%b a=%0d d=%h want 1 1 2 a5a5a5a5", gntB, wrEn, wrAddr, wrData);
        end
        reqB = 0;
        @(negedge clk);
        checks++;
        if (mem[2] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL rw_mem got %h want a5a5a5a5", mem[2]);
        end
    endtask

    task automatic test_reset_abort();
        reqA = 1; weA = 1; addrA = 6; dataA = 32'hCAFEF00D; reqB = 0;
        @(negedge clk);
        reset = 1; reqA = 0;
        #1;
        checks++;
        if (wrEn !== 1'b0 || gntA !== 1'b0) begin
            errors++;
            $display("FAIL abort_issue got we%b gA%b want 0 0", wrEn, gntA);
        end
        @(negedge clk);
        checks++;
        if ({gntA, gntB, rdValidA, rdValidB, wrEn, busy} !== 6'b0 ||
            wrAddr !== 3'd0 || rdAddr !== 3'd0 || wrData !== 32'd0 || rdDataOut !== 32'd0) begin
            errors++;
            $display("FAIL abort_after got ctl=%b wa=%0d ra=%0d wd=%h rd=%h want 0",
                     {gntA, gntB, rdValidA, rdValidB, wrEn, busy}, wrAddr, rdAddr, wrData, rdDataOut);
        end
        checks++;
        if (mem[6] === 32'hCAFEF00D) begin
            errors++;
            $display("FAIL abort_mem got %h want not cafef00d", mem[6]);
        end
        reset = 0;
        reqA = 1; weA = 1; addrA = 1; dataA = 32'h0000AAAA;
        reqB = 1; weB = 1; addrB = 4; dataB = 32'h0000BBBB;
        @(negedge clk);
        checks++;
        if (gntA !== 1'b1 || gntB !== 1'b0) begin
            errors++;
            $display("FAIL abort_tie got gA%b gB%b want 1 0", gntA, gntB);
        end
        reqA = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gntB !== 1'b1 || wrEn !== 1'b1 || wrAddr !== 3'd4) begin
            errors++;
            $display("FAIL abort_tie_b got gB%b we%b a=%0d want 1 1 4", gntB, wrEn, wrAddr);
        end
        reqB = 0;
        @(negedge clk);
    endtask

    task automatic test_pulse_ignored();
        reqA = 1; weA = 0; addrA = 3;
        @(negedge clk);
        checks++;
        if (gntA !== 1'b1) begin
            errors++;
            $display("FAIL pulse_gntA got %b want 1", gntA);
        end
        reqA = 0;
        @(negedge clk);
        checks++;
        if (rdValidA !== 1'b1 || rdDataOut !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pulse_resp got rvA%b d=%h want 1 deadbeef", rdValidA, rdDataOut);
        end
        reqB = 1; weB = 1; addrB = 0; dataB = 32'h0BAD0BAD;
        @(negedge clk);
        reqB = 0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (gntB !== 1'b0 || wrEn !== 1'b0) begin
                errors++;
                $display("FAIL pulse_ignored k=%0d got gB%b we%b want 0 0", k, gntB, wrEn);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [8];
        logic        pendA, pendB, lastB;
        int          busy_until, tx_iss;
        logic        tx_v, tx_b, tx_we;
        logic [2:0]  tx_addr;
        logic [31:0] tx_data, tx_rd;
        logic        eA, eB, ew, erA, erB, eb;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            ref_mem[r] = $urandom;
            reqA = 1; weA = 1; addrA = r[2:0]; dataA = ref_mem[r];
            @(negedge clk);
            reqA = 0;
            @(negedge clk);
        end
        lastB = 1'b0; pendA = 1'b0; pendB = 1'b0;
        busy_until = 0; tx_iss = 0; tx_v = 1'b0; tx_b = 1'b0; tx_we = 1'b0;
        tx_addr = 3'd0; tx_data = 32'd0; tx_rd = 32'd0;
        for (int c = 0; c < 600; c++) begin
            eA  = tx_v && (c == tx_iss) && !tx_b;
            eB  = tx_v && (c == tx_iss) &&  tx_b;
            ew  = tx_v && (c == tx_iss) &&  tx_we;
            erA = tx_v && !tx_we && (c == tx_iss + 1) && !tx_b;
            erB = tx_v && !tx_we && (c == tx_iss + 1) &&  tx_b;
            eb  = (c < busy_until);
            checks++;
            if ({gntA, gntB, wrEn, rdValidA, rdValidB, busy} !== {eA, eB, ew, erA, erB, eb}) begin
                errors++;
                $display("FAIL rand_ctl c=%0d got %b want %b", c,
                         {gntA, gntB, wrEn, rdValidA, rdValidB, busy}, {eA, eB, ew, erA, erB, eb});
            end
            if (ew) begin
                checks++;
                if (wrAddr !== tx_addr || wrData !== tx_data) begin
                    errors++;
                    $display("FAIL rand_wr c=%0d got a=%0d d=%h want a=%0d d=%h", c, wrAddr, wrData, tx_addr, tx_data);
                end
            end
            if (tx_v && (c == tx_iss) && !tx_we) begin
                checks++;
                if (rdAddr !== tx_addr) begin
                    errors++;
                    $display("FAIL rand_rdaddr c=%0d got %0d want %0d", c, rdAddr, tx_addr);
                end
            end
            if (erA || erB) begin
                checks++;
                if (rdDataOut !== tx_rd) begin
                    errors++;
                    $display("FAIL rand_rddata c=%0d got %h want %h", c, rdDataOut, tx_rd);
                end
            end
            if (tx_v && (c == tx_iss)) begin
                if (tx_b) pendB = 1'b0; else pendA = 1'b0;
            end
            if (!pendA) begin
                if ($urandom_range(0, 2) == 0) begin
                    pendA = 1'b1; reqA = 1'b1; weA = 1'($urandom_range(0, 1));
                    addrA = 3'($urandom_range(0, 7)); dataA = $urandom;
                end else begin
                    reqA = (c < busy_until) && ($urandom_range(0, 3) == 0);
                end
            end
            if (!pendB) begin
                if ($urandom_range(0, 2) == 0) begin
                    pendB = 1'b1; reqB = 1'b1; weB = 1'($urandom_range(0, 1));
                    addrB = 3'($urandom_range(0, 7)); dataB = $urandom;
                end else begin
                    reqB = (c < busy_until) && ($urandom_range(0, 3) == 0);
                end
            end
            // Arbiter idle this cycle: the next edge starts a transaction.
            if (c >= busy_until && (pendA || pendB)) begin
                tx_b    = pendB && (!pendA || !lastB);
                lastB   = tx_b;
                tx_v    = 1'b1;
                tx_iss  = c + 1;
                tx_we   = tx_b ? weB : weA;
                tx_addr = tx_b ? addrB : addrA;
                tx_data = tx_b ? dataB : dataA;
                if (tx_we) begin
                    ref_mem[tx_addr] = tx_data;
                    busy_until = c + 2;
                end else begin
                    tx_rd = ref_mem[tx_addr];
                    busy_until = c + 3;
                end
            end
            @(negedge clk);
        end
        reqA = 0; reqB = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        reqA = 0; reqB = 0; weA = 0; weB = 0;
        addrA = 0; addrB = 0; dataA = 0; dataB = 0;
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_rw_same_addr();
        test_reset_abort();
        test_pulse_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
